// File: rtl/collective_injector.sv
// collective_injector: source side of one router inject port. Accepts a collective descriptor,
// then turns a stream of payload words into flits (one flit per accepted word) and paces them
// onto the router inject port, which has no back-pressure of its own.
//
// Optional feature: define INJ_TAG_SEQ_EN to replace the descriptor tag with an internal 8-bit
// message counter that advances on every completed message (including zero-length ones).
//
// Ports
//   clk_i            clock, rising edge
//   rst_ni           asynchronous active-low reset
//   desc_valid_i     descriptor offered
//   desc_ready_o     descriptor accepted when valid & ready (only while idle)
//   desc_op_i        opcode, op[3:2]==2'b11 marks a reduce-special flit
//   desc_alg_i       algorithm type
//   desc_tag_i       tag (ignored when INJ_TAG_SEQ_EN is defined)
//   desc_ctx_i       context id
//   desc_rank_i      rank
//   desc_dst_i       {dst_z, dst_y, dst_x}
//   desc_children_i  children field copied into every flit of the message
//   desc_len_i       number of flits in the message (0 is legal)
//   pay_valid_i      payload word offered
//   pay_ready_o      payload word accepted when valid & ready
//   pay_data_i       payload word
//   inject_hold_i    1 blocks launching new flits
//   inject_flit_o    registered flit; all-zero in cycles with no launch
//   busy_o           message in progress
//   msg_done_o       one-cycle pulse when a message finishes
//
// Flit layout, LSB up: payload | op 4 | alg 2 | tag 8 | ctx 8 | rank 9 | src x,y,z 3 each |
// dst x,y,z 3 each | valid 1 | children lg_numprocs.
module collective_injector #(
  parameter int unsigned cur_x        = 0,
  parameter int unsigned cur_y        = 0,
  parameter int unsigned cur_z        = 0,
  parameter int unsigned lg_numprocs  = 3,
  parameter int unsigned PayloadWidth = 32,
  parameter int unsigned LEN_W        = 8,
  parameter int unsigned INJ_GAP      = 0
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic                                      desc_valid_i,
  output logic                                      desc_ready_o,
  input  logic [3:0]                                desc_op_i,
  input  logic [1:0]                                desc_alg_i,
  input  logic [7:0]                                desc_tag_i,
  input  logic [7:0]                                desc_ctx_i,
  input  logic [8:0]                                desc_rank_i,
  input  logic [8:0]                                desc_dst_i,
  input  logic [lg_numprocs-1:0]                    desc_children_i,
  input  logic [LEN_W-1:0]                          desc_len_i,
  input  logic                                      pay_valid_i,
  output logic                                      pay_ready_o,
  input  logic [PayloadWidth-1:0]                   pay_data_i,
  input  logic                                      inject_hold_i,
  output logic [PayloadWidth+50+lg_numprocs-1:0]    inject_flit_o,
  output logic                                      busy_o,
  output logic                                      msg_done_o
);

  localparam int unsigned FlitChildWidth = PayloadWidth + 50 + lg_numprocs;
  localparam int unsigned GapW = (INJ_GAP > 0) ? $clog2(INJ_GAP + 1) : 1;
  localparam logic [GapW-1:0] GapLoad = GapW'(INJ_GAP);
  localparam logic [8:0] SrcXyz = {3'(cur_z), 3'(cur_y), 3'(cur_x)};

  typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

  state_e                    state_q, state_d;
  logic [LEN_W-1:0]          remaining_q, remaining_d;
  logic [GapW-1:0]           gap_q, gap_d;
  logic [FlitChildWidth-1:0] flit_q, flit_d;

  // Descriptor fields held for the whole message.
  logic [3:0]             op_q;
  logic [1:0]             alg_q;
  logic [7:0]             ctx_q;
  logic [8:0]             rank_q;
  logic [8:0]             dst_q;
  logic [lg_numprocs-1:0] children_q;
  logic [7:0]             tag_field;

  logic desc_accept;
  logic pay_accept;

  assign desc_accept = desc_valid_i & desc_ready_o;
  assign pay_accept  = pay_valid_i & pay_ready_o;

`ifdef INJ_TAG_SEQ_EN
  logic [7:0] tag_seq_q, tag_seq_d;
  logic       unused_tag;

  assign unused_tag = ^desc_tag_i;
  assign tag_field  = tag_seq_q;

  always_comb begin
    tag_seq_d = tag_seq_q;
    if (state_q == StDone) tag_seq_d = tag_seq_q + 8'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) tag_seq_q <= 8'd0;
    else         tag_seq_q <= tag_seq_d;
  end
`else
  logic [7:0] tag_q;

  assign tag_field = tag_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)          tag_q <= 8'd0;
    else if (desc_accept) tag_q <= desc_tag_i;
  end
`endif

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (desc_accept) state_d = (desc_len_i == '0) ? StDone : StSend;
      end
      StSend: begin
        if (pay_accept && (remaining_q == LEN_W'(1))) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs. desc_ready is gated by reset so it stays low while reset is held.
  always_comb begin
    desc_ready_o = rst_ni & (state_q == StIdle);
    pay_ready_o  = (state_q == StSend) & ~inject_hold_i & (gap_q == '0);
    busy_o       = (state_q != StIdle);
    msg_done_o   = (state_q == StDone);
  end

  // Datapath next-state: flit counter, pacing gap and the outgoing flit.
  always_comb begin
    remaining_d = remaining_q;
    gap_d       = gap_q;
    flit_d      = '0;
    // The gap counts down regardless of hold; hold only gates new launches.
    if (gap_q != '0) gap_d = gap_q - GapW'(1);
    if (desc_accept) remaining_d = desc_len_i;
    if (pay_accept) begin
      remaining_d = remaining_q - LEN_W'(1);
      gap_d       = GapLoad;
      flit_d      = {children_q, 1'b1, dst_q, SrcXyz, rank_q, ctx_q, tag_field, alg_q, op_q,
                     pay_data_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      remaining_q <= '0;
      gap_q       <= '0;
      flit_q      <= '0;
    end else begin
      remaining_q <= remaining_d;
      gap_q       <= gap_d;
      flit_q      <= flit_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q       <= '0;
      alg_q      <= '0;
      ctx_q      <= '0;
      rank_q     <= '0;
      dst_q      <= '0;
      children_q <= '0;
    end else if (desc_accept) begin
      op_q       <= desc_op_i;
      alg_q      <= desc_alg_i;
      ctx_q      <= desc_ctx_i;
      rank_q     <= desc_rank_i;
      dst_q      <= desc_dst_i;
      children_q <= desc_children_i;
    end
  end

  assign inject_flit_o = flit_q;

endmodule

// File: tb/tb_collective_injector.sv
// Bench for collective_injector. Two instances: u0 (node 1/2/3, back-to-back injection) and
// u1 (node 0/0/0, two idle cycles between flits). A message-level model predicts every output
// on every cycle; directed tests add hand-computed literal expectations.
module tb_collective_injector;

  localparam int FW = 85;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        desc_valid    [2];
  logic [3:0]  desc_op       [2];
  logic [1:0]  desc_alg      [2];
  logic [7:0]  desc_tag      [2];
  logic [7:0]  desc_ctx      [2];
  logic [8:0]  desc_rank     [2];
  logic [8:0]  desc_dst      [2];
  logic [2:0]  desc_children [2];
  logic [7:0]  desc_len      [2];
  logic        pay_valid     [2];
  logic [31:0] pay_data      [2];
  logic        hold          [2];
  logic        desc_ready    [2];
  logic        pay_ready     [2];
  logic        busy          [2];
  logic        msg_done      [2];
  logic [FW-1:0] flit        [2];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Model state: message in flight, flits left, cycle of last accepted word, pending outputs.
  bit          in_m   [2];
  bit          done_m [2];
  int          left_m [2];
  int          last_m [2];
  logic [FW-1:0] fl_m [2];
  logic [3:0]  op_m   [2];
  logic [1:0]  alg_m  [2];
  logic [7:0]  tag_m  [2];
  logic [7:0]  ctx_m  [2];
  logic [7:0]  seq_m  [2];
  logic [8:0]  rank_m [2];
  logic [8:0]  dst_m  [2];
  logic [2:0]  ch_m   [2];

  // Observations of u0 / u1 used by the literal checks.
  logic [FW-1:0] cap0_flit[$];
  int            cap0_cyc[$];
  int            done0_cyc[$];
  int            cap1_cyc[$];

  always #5 clk = ~clk;

  collective_injector #(
    .cur_x(1), .cur_y(2), .cur_z(3), .lg_numprocs(3), .PayloadWidth(32), .LEN_W(8), .INJ_GAP(0)
  ) u0 (
    .clk_i(clk), .rst_ni(rst_n),
    .desc_valid_i(desc_valid[0]), .desc_ready_o(desc_ready[0]), .desc_op_i(desc_op[0]),
    .desc_alg_i(desc_alg[0]), .desc_tag_i(desc_tag[0]), .desc_ctx_i(desc_ctx[0]),
    .desc_rank_i(desc_rank[0]), .desc_dst_i(desc_dst[0]), .desc_children_i(desc_children[0]),
    .desc_len_i(desc_len[0]), .pay_valid_i(pay_valid[0]), .pay_ready_o(pay_ready[0]),
    .pay_data_i(pay_data[0]), .inject_hold_i(hold[0]), .inject_flit_o(flit[0]),
    .busy_o(busy[0]), .msg_done_o(msg_done[0])
  );

  collective_injector #(
    .cur_x(0), .cur_y(0), .cur_z(0), .lg_numprocs(3), .PayloadWidth(32), .LEN_W(8), .INJ_GAP(2)
  ) u1 (
    .clk_i(clk), .rst_ni(rst_n),
    .desc_valid_i(desc_valid[1]), .desc_ready_o(desc_ready[1]), .desc_op_i(desc_op[1]),
    .desc_alg_i(desc_alg[1]), .desc_tag_i(desc_tag[1]), .desc_ctx_i(desc_ctx[1]),
    .desc_rank_i(desc_rank[1]), .desc_dst_i(desc_dst[1]), .desc_children_i(desc_children[1]),
    .desc_len_i(desc_len[1]), .pay_valid_i(pay_valid[1]), .pay_ready_o(pay_ready[1]),
    .pay_data_i(pay_data[1]), .inject_hold_i(hold[1]), .inject_flit_o(flit[1]),
    .busy_o(busy[1]), .msg_done_o(msg_done[1])
  );

  function automatic logic [8:0] src_of(input int i);
    return (i == 0) ? 9'o321 : 9'o000;
  endfunction

  function automatic int gap_of(input int i);
    return (i == 0) ? 0 : 2;
  endfunction

  function automatic logic [FW-1:0] mk_flit(input logic [2:0] ch, input logic [8:0] dst,
                                            input logic [8:0] src, input logic [8:0] rank,
                                            input logic [7:0] ctx, input logic [7:0] tag,
                                            input logic [1:0] alg, input logic [3:0] op,
                                            input logic [31:0] pay);
    return {ch, 1'b1, dst, src, rank, ctx, tag, alg, op, pay};
  endfunction

  task automatic chk(input string nm, input int i, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d cyc=%0d actual=%0h required=%0h", nm, i, cyc, act, exp);
    end
  endtask

  // Compare + model step, once per cycle on the falling edge (inputs are stable then).
  always @(negedge clk) begin
    bit          e_pr;
    logic [7:0]  tag_use;
    logic [FW-1:0] fl_nx;
    bit          done_nx;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        chk("rst_flit", i, flit[i], '0);
        chk("rst_busy", i, busy[i], 0);
        chk("rst_done", i, msg_done[i], 0);
        chk("rst_desc_ready", i, desc_ready[i], 0);
        chk("rst_pay_ready", i, pay_ready[i], 0);
        in_m[i] = 0; done_m[i] = 0; left_m[i] = 0; last_m[i] = -100;
        fl_m[i] = '0; seq_m[i] = 8'd0;
      end else begin
        e_pr = in_m[i] && !hold[i] && ((cyc - last_m[i]) > gap_of(i));
        chk("flit", i, flit[i], fl_m[i]);
        chk("desc_ready", i, desc_ready[i], !(in_m[i] || done_m[i]));
        chk("pay_ready", i, pay_ready[i], e_pr);
        chk("busy", i, busy[i], in_m[i] || done_m[i]);
        chk("msg_done", i, msg_done[i], done_m[i]);
        if (i == 0) begin
          if (flit[0][81]) begin cap0_flit.push_back(flit[0]); cap0_cyc.push_back(cyc); end
          if (msg_done[0]) done0_cyc.push_back(cyc);
        end else if (flit[1][81]) begin
          cap1_cyc.push_back(cyc);
        end
        fl_nx = '0;
        done_nx = 0;
        if (done_m[i]) begin
          seq_m[i] = seq_m[i] + 8'd1;
        end else if (!in_m[i]) begin
          if (desc_valid[i]) begin
            op_m[i] = desc_op[i]; alg_m[i] = desc_alg[i]; tag_m[i] = desc_tag[i];
            ctx_m[i] = desc_ctx[i]; rank_m[i] = desc_rank[i]; dst_m[i] = desc_dst[i];
            ch_m[i] = desc_children[i];
            if (desc_len[i] == 8'd0) done_nx = 1;
            else begin in_m[i] = 1; left_m[i] = int'(desc_len[i]); end
          end
        end else if (pay_valid[i] && e_pr) begin
`ifdef INJ_TAG_SEQ_EN
          tag_use = seq_m[i];
`else
          tag_use = tag_m[i];
`endif
          fl_nx = mk_flit(ch_m[i], dst_m[i], src_of(i), rank_m[i], ctx_m[i], tag_use, alg_m[i],
                          op_m[i], pay_data[i]);
          left_m[i]--;
          last_m[i] = cyc;
          if (left_m[i] == 0) begin in_m[i] = 0; done_nx = 1; end
        end
        fl_m[i] = fl_nx;
        done_m[i] = done_nx;
      end
    end
  end

  // Offers a descriptor, then streams words base*(k+1) with pay_valid held high. Optionally
  // raises hold together with word hold_after for 5 cycles, or stops after stop_after words.
  task automatic send_msg(input int i, input int len, input logic [3:0] op,
                          input logic [7:0] tag, input logic [8:0] dst, input logic [31:0] base,
                          input int hold_after, input int stop_after);
    int n;
    int k;
    bit held;
    bit acc;
    desc_valid[i] = 1'b1;
    desc_op[i] = op;
    desc_alg[i] = op[1:0] ^ 2'b01;
    desc_tag[i] = tag;
    desc_ctx[i] = tag ^ 8'h3C;
    desc_rank[i] = {1'b1, tag} - 9'd5;
    desc_dst[i] = dst;
    desc_children[i] = tag[2:0] ^ 3'b101;
    desc_len[i] = 8'(len);
    n = 0;
    @(negedge clk);
    while (!desc_ready[i] && n < 50) begin @(negedge clk); n++; end
    chk("desc_wait_bound", i, n < 50, 1);
    @(posedge clk); #1;
    desc_valid[i] = 1'b0;
    k = 0; n = 0; held = 0;
    while (k < len && k != stop_after && n < 200) begin
      pay_valid[i] = 1'b1;
      pay_data[i] = base * 32'(k + 1);
      if (k == hold_after && !held) begin
        hold[i] = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        hold[i] = 1'b0;
        held = 1;
        n += 5;
      end
      @(negedge clk);
      acc = pay_ready[i];
      @(posedge clk); #1;
      n++;
      if (acc) k++;
    end
    pay_valid[i] = 1'b0;
    chk("pay_wait_bound", i, n < 200, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  int nd;
  logic [7:0] exp_tag;

  initial begin
    for (int i = 0; i < 2; i++) begin
      desc_valid[i] = 0; desc_op[i] = 0; desc_alg[i] = 0; desc_tag[i] = 0; desc_ctx[i] = 0;
      desc_rank[i] = 0; desc_dst[i] = 0; desc_children[i] = 0; desc_len[i] = 0;
      pay_valid[i] = 0; pay_data[i] = 0; hold[i] = 0;
    end

    // Reset held while inputs toggle.
    repeat (4) begin
      @(posedge clk); #1;
      desc_valid[0] = ~desc_valid[0];
      desc_len[0] = 8'd3;
      pay_valid[0] = 1'b1;
      pay_data[0] = $urandom;
    end
    desc_valid[0] = 0; pay_valid[0] = 0; desc_len[0] = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_release", 0, desc_ready[0], 1);
    @(posedge clk); #1;

    // len=3, op C, dst 0o123, words 0x11/0x22/0x33 back-to-back.
    cap0_flit.delete(); cap0_cyc.delete(); done0_cyc.delete();
    send_msg(0, 3, 4'hC, 8'hA5, 9'o123, 32'h11, -1, -1);
    idle(3);
    chk("l3_count", 0, cap0_flit.size(), 3);
    if (cap0_flit.size() == 3) begin
      for (int k = 0; k < 3; k++) chk("l3_payload", 0, cap0_flit[k][31:0], 32'h11 * (k + 1));
      chk("l3_op_special", 0, cap0_flit[0][35:34], 2'b11);
      chk("l3_src", 0, cap0_flit[1][71:63], 9'o321);
      chk("l3_dst", 0, cap0_flit[2][80:72], 9'o123);
      chk("l3_back_to_back", 0, cap0_cyc[2] - cap0_cyc[0], 2);
      // Done pulse appears in the cycle after the last word is accepted, i.e. with the last flit.
      chk("l3_done_cycle", 0, (done0_cyc.size() == 1) ? done0_cyc[0] : -1, cap0_cyc[2]);
    end

    // Gap 2, len 4, pay_valid always high: one flit every 3 cycles.
    cap1_cyc.delete();
    send_msg(1, 4, 4'h5, 8'h3E, 9'o456, 32'h100, -1, -1);
    idle(3);
    chk("gap_count", 1, cap1_cyc.size(), 4);
    if (cap1_cyc.size() == 4)
      for (int k = 1; k < 4; k++) chk("gap_spacing", 1, cap1_cyc[k] - cap1_cyc[k - 1], 3);

    // Zero-length message: no flit, one done pulse.
    cap0_flit.delete(); nd = done0_cyc.size();
    send_msg(0, 0, 4'h1, 8'h0F, 9'o007, 32'h0, -1, -1);
    idle(3);
    chk("l0_no_flit", 0, cap0_flit.size(), 0);
    chk("l0_one_done", 0, done0_cyc.size() - nd, 1);

    // Hold for 5 cycles before the third word.
    cap0_flit.delete(); cap0_cyc.delete();
    send_msg(0, 5, 4'h3, 8'h21, 9'o765, 32'h1000, 2, -1);
    idle(3);
    chk("hold_count", 0, cap0_flit.size(), 5);
    if (cap0_flit.size() == 5) begin
      for (int k = 0; k < 5; k++) chk("hold_payload", 0, cap0_flit[k][31:0], 32'h1000 * (k + 1));
      chk("hold_stall", 0, cap0_cyc[2] - cap0_cyc[1], 6);
    end

    // Reset after 2 of 5 words, then a clean message.
    send_msg(0, 5, 4'h6, 8'h44, 9'o111, 32'h500, -1, 2);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    cap0_flit.delete();
    idle(2);
    chk("post_rst_quiet", 0, cap0_flit.size(), 0);
    send_msg(0, 2, 4'hD, 8'h42, 9'o222, 32'h77, -1, -1);
    idle(3);
    chk("post_rst_count", 0, cap0_flit.size(), 2);
`ifdef INJ_TAG_SEQ_EN
    exp_tag = 8'h00;
`else
    exp_tag = 8'h42;
`endif
    if (cap0_flit.size() == 2) begin
      chk("post_rst_payload", 0, cap0_flit[1][31:0], 32'hEE);
      chk("post_rst_tag", 0, cap0_flit[0][45:38], exp_tag);
    end

    // 255 more zero-length messages make 256 completions since reset; the tag wraps to 0.
    for (int m = 0; m < 255; m++) send_msg(0, 0, 4'h2, 8'(m), 9'o000, 32'h0, -1, -1);
    cap0_flit.delete();
    send_msg(0, 1, 4'hF, 8'h99, 9'o333, 32'hCAFE, -1, -1);
    idle(3);
`ifdef INJ_TAG_SEQ_EN
    exp_tag = 8'h00;
`else
    exp_tag = 8'h99;
`endif
    chk("wrap_count", 0, cap0_flit.size(), 1);
    if (cap0_flit.size() == 1) begin
      chk("wrap_tag", 0, cap0_flit[0][45:38], exp_tag);
      chk("wrap_payload", 0, cap0_flit[0][31:0], 32'hCAFE);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog");
  end

endmodule
